cpu_trace_buffer: RTL
=====================

Name: cpu_trace_buffer

Overview:
Synthesisable on-chip trace capture for the single-cycle/pipelined CPU core. It records PC plus memory-interface activity into a parametrised circular buffer. Capture stops after a halt or timeout trigger, with a configurable post-trigger window. A host or testbench reads entries out oldest-first, so post-synthesis and FPGA runs can be debugged without simulator hierarchy access.

Parameters:
ADDR_W, 16, width of pc and mem_addr
DATA_W, 16, width of mem_data_in / mem_data_out
DEPTH, 16, trace entries; power of two, >= 2
TIMEOUT_CYCLES, 1000000, capture cycles before forced trigger; >= 1
POST_TRIG, 2, cycles captured after the trigger cycle; 0 allowed
CAPTURE_MODE, 0, 0 = record every capture cycle; 1 = record only cycles with mem_en=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
arm  in  1  start/restart capture (pulse)
hlt  in  1  CPU halt indication
pc  in  ADDR_W  current PC
mem_addr  in  ADDR_W  memory address
mem_en  in  1  memory enable
mem_wr  in  1  memory write
mem_data_valid  in  1  memory read data valid
mem_data_in  in  DATA_W  write data to memory
mem_data_out  in  DATA_W  read data from memory
rd_idx  in  $clog2(DEPTH)  readout index, 0 = oldest
rd_entry  out  2*ADDR_W+2*DATA_W+3  {pc, mem_addr, mem_data_in, mem_data_out, mem_en, mem_wr, mem_data_valid}
entry_count  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
wrapped  out  1  buffer overwrote at least one entry
capturing  out  1  state is CAPTURE or POST
done  out  1  capture finished
halted  out  1  trigger was hlt
timed_out  out  1  trigger was timeout

Behaviour:
- Reset (async, rst=1): state IDLE; wr_ptr, entry_count, cycle_cnt, post_cnt = 0; wrapped, done, halted, timed_out, capturing = 0; rd_entry = 0.
- States: IDLE, CAPTURE, POST, DONE.
- IDLE/DONE + arm=1: next cycle enters CAPTURE. That same edge clears wr_ptr, entry_count, wrapped, cycle_cnt, done, halted, timed_out. No entry is written on the arm cycle.
- arm in CAPTURE or POST: ignored.
- Qualified cycle: in CAPTURE or POST, and (CAPTURE_MODE=0 or mem_en=1).
- On a qualified cycle: write the sampled inputs at wr_ptr; wr_ptr increments modulo DEPTH.
- When wr_ptr wraps DEPTH-1 -> 0, set wrapped (sticky until next arm).
- entry_count increments per write and saturates at DEPTH.
- CAPTURE: cycle_cnt increments every cycle, whether qualified or not.
  - hlt=1: set halted; post_cnt = POST_TRIG; go to POST, or go to DONE if POST_TRIG=0. The trigger cycle itself is recorded if qualified.
  - else cycle_cnt == TIMEOUT_CYCLES-1: set timed_out; same transition as hlt.
  - hlt and timeout on the same cycle: halted=1, timed_out=0.
- POST: record qualified cycles. post_cnt decrements each cycle; on the cycle post_cnt==1, go to DONE. hlt is ignored.
- DONE: done=1, capturing=0. No writes. Flags and buffer contents are held.
- Readout: registered, 1-cycle latency; legal in any state.
  - Physical index = wrapped ? (wr_ptr + rd_idx) mod DEPTH : rd_idx.
  - rd_idx >= entry_count returns all zeros.
  - Same-cycle write and read of one location returns old data (read-before-write).
- No state outside IDLE returns to IDLE except via rst. Reset mid-capture discards everything.

Decomposition:
- trace_pkg: state enum (IDLE, CAPTURE, POST, DONE); packed trace_entry_t struct; flag bit positions; ENTRY_W function of ADDR_W/DATA_W.
- Sub-module trace_ram: DEPTH x ENTRY_W, one synchronous write port, one registered read port, no reset on storage.
- cpu_trace_buffer holds the FSM, pointers, counters and index translation.

Test Plan:
- Reset while capturing (10 entries written) -> all outputs 0 within the same cycle. rd_entry=0 on the first post-reset clock.
- DEPTH=4, MODE 0, POST_TRIG=2; arm, then pc=0x0000+2n on capture cycle n, hlt=1 at n=3 -> records n=0..5 and done the next cycle; halted=1, wrapped=1, entry_count=4; rd_idx 0..3 -> pc 0x0004, 0x0006, 0x0008, 0x000A.
- DEPTH=8, MODE 1; 20 capture cycles with mem_en=1 only at n=2 (wr=1, addr 0x0100, din 0xBEEF) and n=7 (valid=1, dout 0x1234); hlt at n=9 -> entry_count=2, wrapped=0; idx0={addr 0x0100, din 0xBEEF, flags 110}; idx1 has dout 0x1234, flags 101; idx2 reads 0.
- TIMEOUT_CYCLES=5, POST_TRIG=0, hlt held 0 -> timed_out=1, halted=0, done on the cycle after capture cycle 4; entry_count=5, wrapped=0.
- TIMEOUT_CYCLES=5; hlt=1 exactly at capture cycle 4 -> halted=1, timed_out=0.
- In DONE, pulse arm -> flags and entry_count clear, capturing=1 next cycle; new capture overwrites from index 0. arm pulsed during POST has no effect.

Source files
------------

// File: rtl/cpu_trace_buffer_pkg.sv
// cpu_trace_buffer_pkg
//   Shared types and constants for the CPU trace buffer.
//   - trace_state_t : capture FSM states
//   - FLAG_*_BIT    : bit positions of the flag field in a trace entry
//   - entry_w()     : width of one trace entry for given address/data widths
//   - trace_entry_t : entry layout at the default 16-bit widths (field order
//                     matches the packed rd_entry_o word, MSB first)
package cpu_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam int FLAGS_W        = 3;
  localparam int FLAG_VALID_BIT = 0;
  localparam int FLAG_WR_BIT    = 1;
  localparam int FLAG_EN_BIT    = 2;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  function automatic int entry_w(input int addr_w, input int data_w);
    return 2 * addr_w + 2 * data_w + FLAGS_W;
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_ADDR_W-1:0] mem_addr;
    logic [DEF_DATA_W-1:0] mem_data_in;
    logic [DEF_DATA_W-1:0] mem_data_out;
    logic                  mem_en;
    logic                  mem_wr;
    logic                  mem_data_valid;
  } trace_entry_t;

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// cpu_trace_buffer_ram
//   DEPTH x WIDTH trace storage. One synchronous write port and one registered
//   read port. Storage has no reset. A read and a write to the same address on
//   the same edge return the old contents.
// Ports:
//   clk        - clock
//   wr_en_i    - write enable
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address, data appears after the next edge
//   rd_data_o  - registered read data
module cpu_trace_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 67,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   Circular trace capture of CPU PC and memory-interface activity. Capture is
//   started by arm_i, stops after a halt or timeout trigger plus a post-trigger
//   window, and entries are read out oldest-first through rd_idx_i.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | after reset, nothing captured, waiting for arm_i
//   CAPTURE  | recording, counting cycles, watching hlt_i and timeout
//   POST     | recording the post-trigger window, hlt_i ignored
//   DONE     | capture finished, buffer and flags held until next arm_i
//
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   arm_i                 - start/restart capture (honoured in IDLE/DONE)
//   hlt_i                 - CPU halt indication (trigger)
//   pc_i, mem_addr_i      - PC and memory address
//   mem_en_i, mem_wr_i    - memory enable / write
//   mem_data_valid_i      - memory read data valid
//   mem_data_in_i/out_i   - write data / read data
//   rd_idx_i              - readout index, 0 = oldest
//   rd_entry_o            - {pc, addr, din, dout, en, wr, valid}, 1-cycle latency
//   entry_count_o         - valid entries, saturates at DEPTH
//   wrapped_o             - write pointer has wrapped since arm
//   capturing_o, done_o   - in CAPTURE/POST, capture finished
//   halted_o, timed_out_o - trigger cause
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int POST_TRIG      = 2,
  parameter int CAPTURE_MODE   = 0,
  localparam int PTR_W         = $clog2(DEPTH),
  localparam int ENTRY_W       = entry_w(ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm_i,
  input  logic               hlt_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic               mem_en_i,
  input  logic               mem_wr_i,
  input  logic               mem_data_valid_i,
  input  logic [DATA_W-1:0]  mem_data_in_i,
  input  logic [DATA_W-1:0]  mem_data_out_i,
  input  logic [PTR_W-1:0]   rd_idx_i,
  output logic [ENTRY_W-1:0] rd_entry_o,
  output logic [PTR_W:0]     entry_count_o,
  output logic               wrapped_o,
  output logic               capturing_o,
  output logic               done_o,
  output logic               halted_o,
  output logic               timed_out_o
);

  localparam int CYC_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int POST_W = $clog2(POST_TRIG + 1) + 1;

  localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_ONE    = CYC_W'(1);
  localparam logic [POST_W-1:0] POST_LOAD  = POST_W'(POST_TRIG);
  localparam logic [POST_W-1:0] POST_ONE   = POST_W'(1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]    COUNT_ONE  = (PTR_W + 1)'(1);

  trace_state_t        state_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W:0]      entry_count_q;
  logic [CYC_W-1:0]    cycle_cnt_q;
  logic [POST_W-1:0]   post_cnt_q;
  logic                wrapped_q;
  logic                capturing_q;
  logic                done_q;
  logic                halted_q;
  logic                timed_out_q;
  logic                rd_ok_q;

  logic                qualified;
  logic                timeout_hit;
  logic                rd_ok_d;
  logic [PTR_W-1:0]    rd_phys;
  logic [FLAGS_W-1:0]  flags;
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  ram_rd_data;

  assign qualified   = (state_q == ST_CAPTURE || state_q == ST_POST) &&
                       (CAPTURE_MODE == 0 || mem_en_i);
  assign timeout_hit = (cycle_cnt_q == CYC_LAST);

  always_comb begin
    flags                 = '0;
    flags[FLAG_EN_BIT]    = mem_en_i;
    flags[FLAG_WR_BIT]    = mem_wr_i;
    flags[FLAG_VALID_BIT] = mem_data_valid_i;
  end

  assign wr_entry = {pc_i, mem_addr_i, mem_data_in_i, mem_data_out_i, flags};

  // Once wrapped, wr_ptr points at the oldest entry; DEPTH is a power of two
  // so the sum wraps naturally in PTR_W bits.
  assign rd_phys = wrapped_q ? (wr_ptr_q + rd_idx_i) : rd_idx_i;
  assign rd_ok_d = ({1'b0, rd_idx_i} < entry_count_q);

  cpu_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (qualified),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_phys),
    .rd_data_o (ram_rd_data)
  );

  // The RAM has no reset, so the registered valid bit masks its output to
  // zero both after reset and for indices beyond entry_count.
  assign rd_entry_o = rd_ok_q ? ram_rd_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      entry_count_q <= '0;
      cycle_cnt_q   <= '0;
      post_cnt_q    <= '0;
      wrapped_q     <= 1'b0;
      capturing_q   <= 1'b0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
      timed_out_q   <= 1'b0;
      rd_ok_q       <= 1'b0;
    end else begin
      rd_ok_q <= rd_ok_d;

      // Writes only happen in CAPTURE/POST, so they never collide with the
      // clears done on arm in IDLE/DONE below.
      if (qualified) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (wr_ptr_q == PTR_LAST) wrapped_q <= 1'b1;
        if (entry_count_q != COUNT_FULL) entry_count_q <= entry_count_q + COUNT_ONE;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_q       <= ST_CAPTURE;
            wr_ptr_q      <= '0;
            entry_count_q <= '0;
            wrapped_q     <= 1'b0;
            cycle_cnt_q   <= '0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            timed_out_q   <= 1'b0;
            capturing_q   <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          cycle_cnt_q <= cycle_cnt_q + CYC_ONE;
          if (hlt_i || timeout_hit) begin
            // halt wins over a coincident timeout
            halted_q    <= hlt_i;
            timed_out_q <= ~hlt_i;
            post_cnt_q  <= POST_LOAD;
            if (POST_TRIG == 0) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              capturing_q <= 1'b0;
            end else begin
              state_q <= ST_POST;
            end
          end
        end
        ST_POST: begin
          post_cnt_q <= post_cnt_q - POST_ONE;
          if (post_cnt_q == POST_ONE) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            capturing_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign entry_count_o = entry_count_q;
  assign wrapped_o     = wrapped_q;
  assign capturing_o   = capturing_q;
  assign done_o        = done_q;
  assign halted_o      = halted_q;
  assign timed_out_o   = timed_out_q;

endmodule
